bcd_display_ctrl: RTL and testbench



---
 rtl/bcd_display_ctrl.sv | 143 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Key debounce, page/hold control and iterative shift-add-3 conversion of the
// 18-bit switch value into six BCD digits, three of which are shown at a time.
module bcd_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  keysn,
  input  logic [17:0] sws,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic        page,
  output logic        hold,
  output logic        busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [3:0]    r_keysMeta, r_keysSync;
  logic [17:0]   r_swsMeta, r_swsSync;
  logic [CW-1:0] r_dbCnt [4];
  logic [3:0]    r_keyAcc;
  logic [3:0]    r_press;
  logic          r_page, r_hold;
  logic [1:0]    r_state;
  logic [17:0]   r_shreg, r_lastVal;
  logic [23:0]   r_acc, r_digits;
  logic [4:0]    r_cnt;
  logic [11:0]   r_bcd;
  logic [23:0]   w_accAdj;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_keysMeta <= '0;
      r_keysSync <= '0;
      r_swsMeta  <= '0;
      r_swsSync  <= '0;
    end else begin
      r_keysMeta <= keysn;
      r_keysSync <= r_keysMeta;
      r_swsMeta  <= sws;
      r_swsSync  <= r_swsMeta;
    end
  end

  // Accepted level is the raw polarity (1 = released); a press pulses when it drops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) r_dbCnt[i] <= '0;
      r_keyAcc <= 4'hF;
      r_press  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_keysSync[i] == r_keyAcc[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == CNT_LAST) begin
          r_dbCnt[i]  <= '0;
          r_keyAcc[i] <= r_keysSync[i];
          r_press[i]  <= r_keyAcc[i];
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_page <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      if (r_press[0] && !r_press[1]) r_page <= 1'b0;
      else if (r_press[1] && !r_press[0]) r_page <= 1'b1;
      if (r_press[2]) r_hold <= ~r_hold;
    end
  end

  always_comb begin
    w_accAdj = r_acc;
    for (int d = 0; d < 6; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_accAdj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_lastVal <= '0;
      r_acc     <= '0;
      r_digits  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_hold && ((r_swsSync != r_lastVal) || r_press[3])) r_state <= LOAD;
        end
        LOAD: begin
          r_shreg   <= r_swsSync;
          r_lastVal <= r_swsSync;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          r_acc   <= {w_accAdj[22:0], r_shreg[17]};
          r_shreg <= {r_shreg[16:0], 1'b0};
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd17) r_state <= DONE;
        end
        default: begin
          r_digits <= r_acc;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // A frozen display ignores both page changes and fresh results.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bcd <= '0;
    end else if (!r_hold) begin
      r_bcd <= r_page ? r_digits[23:12] : r_digits[11:0];
    end
  end

  assign bcd0 = r_bcd[3:0];
  assign bcd1 = r_bcd[7:4];
  assign bcd2 = r_bcd[11:8];
  assign page = r_page;
  assign hold = r_hold;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: expected conversion results are queued
// by the stimulus and compared by a monitor once each conversion finishes.
module tb_bcd_display_ctrl;

  logic        clk;
  logic        rstn;
  logic [3:0]  keysn;
  logic [17:0] sws;
  logic [3:0]  bcd0, bcd1, bcd2;
  logic        page, hold, busy;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int busyLen = 0;
  logic prevBusy = 1'b0;
  logic pendingCompare = 1'b0;
  logic busySeen = 1'b0;
  logic prevPage = 1'b0;
  int pageChanges = 0;

  bcd_display_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .keysn(keysn), .sws(sws),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
    .page(page), .hold(hold), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endfunction

  // Monitor: measures each busy window and compares the display one cycle after it closes.
  always @(negedge clk) begin
    if (busy) busySeen = 1'b1;
    if (page != prevPage) pageChanges++;
    prevPage = page;
    if (!rstn) begin
      busyLen = 0;
      prevBusy = 1'b0;
      pendingCompare = 1'b0;
    end else begin
      if (busy) busyLen++;
      if (pendingCompare) begin
        pendingCompare = 1'b0;
        if (expQ.size() == 0) checkOutput("unexpectedResult", 1, 0);
        else checkOutput("bcdResult", {bcd2, bcd1, bcd0}, expQ.pop_front());
      end
      if (prevBusy && !busy) begin
        checkOutput("busyLength", busyLen, 20);
        busyLen = 0;
        pendingCompare = 1'b1;
      end
      prevBusy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int lowCycles);
    keysn = ~mask;
    tick(lowCycles);
    keysn = 4'hF;
    tick(12);
  endtask

  task automatic waitBusyHigh();
    int n = 0;
    while (!busy && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("busyStart", int'(busy), 1);
  endtask

  task automatic checkDisplay(string name, input logic [11:0] expBcd, input logic expPage,
                              input logic expHold);
    checkOutput({name, "_bcd"}, {bcd2, bcd1, bcd0}, expBcd);
    checkOutput({name, "_page"}, int'(page), int'(expPage));
    checkOutput({name, "_hold"}, int'(hold), int'(expHold));
  endtask

  initial begin
    int startChanges;
    rstn  = 1'b0;
    keysn = 4'hF;
    sws   = '0;
    tick(2);
    rstn = 1'b1;
    tick(1);
    checkDisplay("reset", 12'h000, 1'b0, 1'b0);
    checkOutput("resetBusy", int'(busy), 0);
    busySeen = 1'b0;
    tick(50);
    checkOutput("idleNoBusy", int'(busySeen), 0);

    $display("[TB] convert 123456 on page 0, then key1");
    expQ.push_back(12'h456);
    sws = 18'd123456;
    tick(40);
    applyStimulus(4'b0010, 10);
    checkDisplay("key1Page", 12'h123, 1'b1, 1'b0);

    $display("[TB] convert 262143 on page 1, then key0");
    expQ.push_back(12'h262);
    sws = 18'd262143;
    tick(40);
    applyStimulus(4'b0001, 10);
    checkDisplay("key0Page", 12'h143, 1'b0, 1'b0);

    $display("[TB] debounce");
    applyStimulus(4'b0010, 3);
    checkDisplay("shortGlitch", 12'h143, 1'b0, 1'b0);
    startChanges = pageChanges;
    applyStimulus(4'b0010, 8);
    checkOutput("onePageChange", pageChanges - startChanges, 1);
    checkDisplay("longPress", 12'h262, 1'b1, 1'b0);
    applyStimulus(4'b0011, 10);
    checkDisplay("bothKeys", 12'h262, 1'b1, 1'b0);

    $display("[TB] hold");
    applyStimulus(4'b0001, 10);
    expQ.push_back(12'h100);
    sws = 18'd100;
    tick(40);
    applyStimulus(4'b0100, 10);
    checkDisplay("holdOn", 12'h100, 1'b0, 1'b1);
    busySeen = 1'b0;
    sws = 18'd999;
    tick(5);
    applyStimulus(4'b1000, 10);
    checkOutput("holdNoBusy", int'(busySeen), 0);
    checkDisplay("holdFrozen", 12'h100, 1'b0, 1'b1);
    expQ.push_back(12'h999);
    applyStimulus(4'b0100, 10);
    checkOutput("holdOff", int'(hold), 0);
    tick(40);

    $display("[TB] mid-run switch change");
    expQ.push_back(12'h100);
    expQ.push_back(12'h999);
    sws = 18'd100;
    waitBusyHigh();
    tick(5);
    sws = 18'd999;
    tick(60);

    $display("[TB] mid-run reset");
    sws = 18'd123;
    waitBusyHigh();
    tick(10);
    rstn = 1'b0;
    tick(1);
    checkOutput("resetAbortBusy", int'(busy), 0);
    checkDisplay("resetAbort", 12'h000, 1'b0, 1'b0);
    expQ.push_back(12'h123);
    rstn = 1'b1;
    tick(40);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
